operand_pair_fifo: RTL and testbench
====================================

# operand_pair_fifo

Buffers operand pairs for the `toplevel` datapath, one slot per pair of 11-bit `xa` / `xb` operands. Sits directly upstream of `toplevel` and drives its `xa` / `xb` inputs from a small first-word-fall-through queue. Uses valid/ready on both sides, which decouples the operand producer from the reduction stage. Also provides an occupancy count and a synchronous flush.

## Interface
- `WIDTH`, 11: operand width; matches `toplevel` `xa` / `xb`.
- `DEPTH`, 4: number of pair entries; power of two, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all entries.
- `in_valid` in 1: producer presents a pair.
- `in_ready` out 1: FIFO accepts a pair this cycle.
- `in_xa` in WIDTH: operand A.
- `in_xb` in WIDTH: operand B.
- `out_valid` out 1: head pair available.
- `out_ready` in 1: consumer takes the head pair.
- `out_xa` out WIDTH: head operand A, to `toplevel.xa`.
- `out_xb` out WIDTH: head operand B, to `toplevel.xb`.
- `level` out $clog2(DEPTH)+1: current entry count, 0..DEPTH.

## Operation
- Push: `in_valid && in_ready` at a rising edge. The pair is written at the write pointer, and the write pointer increments.
- Pop: `out_valid && out_ready` at a rising edge. The read pointer increments.
- Pointers are $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: low bits are equal and the MSBs differ.
  - `level` = write pointer − read pointer, modulo 2^($clog2(DEPTH)+1).
- `in_ready` = `level != DEPTH`. It depends only on state, with no combinational path from `out_ready`.
- `out_valid` = `level != 0`.
- `out_xa` / `out_xb` show the entry at the read pointer while `out_valid` = 1. They are driven 0 while `out_valid` = 0.
- Simultaneous push and pop when not full and not empty: both take effect and `level` is unchanged.
- Simultaneous push and pop when full: the push is impossible because `in_ready` = 0; the pop proceeds, and `in_ready` = 1 next cycle.
- Push while empty: the pair appears on `out_*` the following cycle. There is no same-cycle bypass.
- Flush:
  - Next edge: pointers = 0, `level` = 0.
  - Any push or pop in the same cycle is discarded.
  - Stored data is not cleared.
- Producer rule: while `in_valid` = 1 and `in_ready` = 0, the producer holds `in_xa` / `in_xb` stable. The FIFO does not check this.
- Entries are never overwritten or dropped except by flush or reset.

## Timing
- Reset, asynchronous:
  - Pointers = 0, `level` = 0, `out_valid` = 0, `in_ready` = 1, `out_xa` = `out_xb` = 0.
  - Storage contents are not reset.
- Reset asserted mid-operation: all entries are lost at once. There is no partial state.
- Latency: 1 cycle from an accepted push to `out_valid` when the FIFO was empty.
- Throughput: 1 pair per cycle in steady state with `DEPTH` ≥ 2.
- All outputs are functions of registered state only: `level`, `in_ready`, `out_valid`, and `out_*` through the storage read mux.
- Wrap-around: pointers roll from 2·DEPTH−1 to 0 with no glitch in `level`.

## Structure
- Shared package `toplevel_pkg` holds:
  - `OPERAND_W` = 11, the single source for `WIDTH` here and in `toplevel`.
  - `PAIR_FIFO_DEPTH` = 4.
- Sub-module `fifo_ptr`: a wrap-bit pointer counter with increment enable, flush, and asynchronous reset. Instantiate it twice, once for read and once for write.
- Storage is a register array of DEPTH × 2·WIDTH. Do not use a RAM macro.

## Test plan
- Reset then idle:
  - Required: `level` = 0, `out_valid` = 0, `in_ready` = 1, `out_xa` = `out_xb` = 0.
- Push one pair (`xa` = 11'h555, `xb` = 11'h2AA) with `out_ready` = 0:
  - Next cycle: `out_valid` = 1, `out_xa` = 11'h555, `out_xb` = 11'h2AA, `level` = 1.
  - Then pulse `out_ready`: `level` = 0, `out_valid` = 0.
- Push 4 pairs (11'h001..11'h004 on `xa`, 11'h7FE..11'h7FB on `xb`) with `out_ready` = 0:
  - Required: `level` = 4, `in_ready` = 0.
  - A fifth `in_valid` is not accepted.
  - Draining returns pairs in order 001/7FE … 004/7FB.
- Full, then `in_valid` = 1 and `out_ready` = 1 together:
  - Cycle 1: only the pop occurs, `level` = 3.
  - Cycle 2: push accepted, `level` = 3.
- Continuous push and pop for 20 cycles with incrementing `xa`:
  - Required: `level` stays 1 and output order is exact across pointer wrap (≥ 2 wraps).
- Mid-operation events:
  - `flush` at `level` = 3 with simultaneous push: `level` = 0 next cycle, `out_valid` = 0, the pushed pair is lost.
  - Asynchronous `rst` pulse mid-cycle at `level` = 2: outputs reach reset values immediately, before the next edge.

Source files
------------

// File: rtl/toplevel_pkg.sv
// Shared definitions for the toplevel datapath and its operand feeder.
//   OPERAND_W       : width of the xa / xb operands (single source for all users)
//   PAIR_FIFO_DEPTH : number of operand-pair slots in operand_pair_fifo
//   pair_pack       : packs one xa/xb pair into a single storage word
package toplevel_pkg;

  localparam int OPERAND_W       = 11;
  localparam int PAIR_FIFO_DEPTH = 4;

  // xa occupies the upper half of a packed pair, xb the lower half.
  function automatic logic [2*OPERAND_W-1:0] pair_pack(
    input logic [OPERAND_W-1:0] xa,
    input logic [OPERAND_W-1:0] xb
  );
    return {xa, xb};
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer counter.
//   clk, rst : rising-edge clock, asynchronous active-high reset (ptr -> 0)
//   flush    : synchronous clear to 0, takes priority over inc
//   inc      : advance pointer by one
//   ptr      : $clog2(DEPTH)+1 bits; the MSB toggles each time the low bits wrap
module fifo_ptr #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inc,
  output logic [AW:0] ptr
);

  // DEPTH is a power of two, so natural binary rollover at 2*DEPTH gives
  // the wrap bit for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/operand_pair_fifo.sv
// First-word-fall-through queue of xa/xb operand pairs feeding toplevel.
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   flush        : synchronous clear of all entries (same-cycle push/pop dropped)
//   in_valid     : producer presents in_xa / in_xb
//   in_ready     : a slot is free (registered-state only)
//   in_xa, in_xb : incoming operand pair
//   out_valid    : head pair present
//   out_ready    : consumer takes the head pair
//   out_xa/out_xb: head pair, forced to 0 while out_valid is low
//   level        : number of stored pairs, 0..DEPTH
module operand_pair_fifo
  import toplevel_pkg::*;
#(
  parameter int WIDTH = OPERAND_W,
  parameter int DEPTH = PAIR_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_xa,
  input  logic [WIDTH-1:0] in_xb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xa,
  output logic [WIDTH-1:0] out_xb,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] head;

  // Status is derived purely from the two registered pointers, so neither
  // ready nor valid has a combinational path from the opposite handshake.
  assign level     = wr_ptr - rd_ptr;
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);

  // Flush wins over any handshake in the same cycle.
  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Storage is data only: no reset, survives flush; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= pair_pack(in_xa, in_xb);
    end
  end

  assign head   = mem[rd_ptr[AW-1:0]];
  assign out_xa = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
  assign out_xb = out_valid ? head[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_operand_pair_fifo.sv
module tb_operand_pair_fifo;

  localparam int W  = 11;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_xa;
  logic [W-1:0]  in_xb;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_xa;
  logic [W-1:0]  out_xb;
  logic [LW-1:0] level;

  int errors = 0;
  int checks = 0;

  operand_pair_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_xa     (in_xa),
    .in_xb     (in_xb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xa    (out_xa),
    .out_xb    (out_xb),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [W-1:0]  xa;
    logic [W-1:0]  xb;
    logic          ordy;
    logic [LW-1:0] lvl;
    logic          ir;
    logic          ov;
    logic [W-1:0]  exa;
    logic [W-1:0]  exb;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic fl, input logic iv, input logic [W-1:0] xa, input logic [W-1:0] xb,
    input logic ordy, input logic [LW-1:0] lvl, input logic ir, input logic ov,
    input logic [W-1:0] exa, input logic [W-1:0] exb
  );
    vec_t v;
    v.fl = fl; v.iv = iv; v.xa = xa; v.xb = xb; v.ordy = ordy;
    v.lvl = lvl; v.ir = ir; v.ov = ov; v.exa = exa; v.exb = exb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [LW-1:0] lvl, input logic ir,
                             input logic ov, input logic [W-1:0] exa, input logic [W-1:0] exb);
    check({tag, ".level"},     32'(level),     32'(lvl));
    check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_xa"},    32'(out_xa),    32'(exa));
    check({tag, ".out_xb"},    32'(out_xb),    32'(exb));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [W-1:0] xa,
                       input logic [W-1:0] xb, input logic ordy);
    flush = fl; in_valid = iv; in_xa = xa; in_xb = xb; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fl iv xa xb ordy | lvl ir ov exa exb
    vecs[0]  = mk(0, 0, 11'h000, 11'h000, 0, 0, 1, 0, 11'h000, 11'h000);
    vecs[1]  = mk(0, 1, 11'h555, 11'h2AA, 0, 1, 1, 1, 11'h555, 11'h2AA);
    vecs[2]  = mk(0, 0, 11'h000, 11'h000, 0, 1, 1, 1, 11'h555, 11'h2AA);
    vecs[3]  = mk(0, 0, 11'h000, 11'h000, 1, 0, 1, 0, 11'h000, 11'h000);
    vecs[4]  = mk(0, 1, 11'h001, 11'h7FE, 0, 1, 1, 1, 11'h001, 11'h7FE);
    vecs[5]  = mk(0, 1, 11'h002, 11'h7FD, 0, 2, 1, 1, 11'h001, 11'h7FE);
    vecs[6]  = mk(0, 1, 11'h003, 11'h7FC, 0, 3, 1, 1, 11'h001, 11'h7FE);
    vecs[7]  = mk(0, 1, 11'h004, 11'h7FB, 0, 4, 0, 1, 11'h001, 11'h7FE);
    vecs[8]  = mk(0, 1, 11'h005, 11'h7FA, 0, 4, 0, 1, 11'h001, 11'h7FE);
    vecs[9]  = mk(0, 1, 11'h005, 11'h7FA, 1, 3, 1, 1, 11'h002, 11'h7FD);
    vecs[10] = mk(0, 1, 11'h005, 11'h7FA, 1, 3, 1, 1, 11'h003, 11'h7FC);
    vecs[11] = mk(0, 0, 11'h000, 11'h000, 1, 2, 1, 1, 11'h004, 11'h7FB);
    vecs[12] = mk(0, 0, 11'h000, 11'h000, 1, 1, 1, 1, 11'h005, 11'h7FA);
    vecs[13] = mk(0, 0, 11'h000, 11'h000, 1, 0, 1, 0, 11'h000, 11'h000);
    vecs[14] = mk(0, 1, 11'h0AA, 11'h011, 0, 1, 1, 1, 11'h0AA, 11'h011);
    vecs[15] = mk(0, 1, 11'h0BB, 11'h022, 0, 2, 1, 1, 11'h0AA, 11'h011);
    vecs[16] = mk(0, 1, 11'h0CC, 11'h033, 0, 3, 1, 1, 11'h0AA, 11'h011);
    vecs[17] = mk(1, 1, 11'h0DD, 11'h044, 0, 0, 1, 0, 11'h000, 11'h000);
    vecs[18] = mk(0, 0, 11'h000, 11'h000, 0, 0, 1, 0, 11'h000, 11'h000);

    rst = 1'b1;
    drive(0, 0, '0, '0, 0);
    step();
    step();
    check_state("reset", 0, 1, 0, 11'h000, 11'h000);
    rst = 1'b0;
    step();
    check_state("idle", 0, 1, 0, 11'h000, 11'h000);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].xa, vecs[i].xb, vecs[i].ordy);
      step();
      check_state($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].ir, vecs[i].ov,
                  vecs[i].exa, vecs[i].exb);
    end

    // Streaming: one entry in flight, push and pop every cycle across wraps.
    drive(0, 1, 11'h100, 11'h6FF, 0);
    step();
    check_state("stream_pre", 1, 1, 1, 11'h100, 11'h6FF);
    for (int i = 1; i <= 20; i++) begin
      drive(0, 1, W'(11'h100 + i), W'(11'h6FF - i), 1);
      step();
      check_state($sformatf("stream%0d", i), 1, 1, 1, W'(11'h100 + i), W'(11'h6FF - i));
    end
    drive(0, 0, '0, '0, 1);
    step();
    check_state("stream_drain", 0, 1, 0, 11'h000, 11'h000);

    // Asynchronous reset in the middle of a cycle at level 2.
    drive(0, 1, 11'h321, 11'h123, 0);
    step();
    drive(0, 1, 11'h456, 11'h654, 0);
    step();
    drive(0, 0, '0, '0, 0);
    check_state("pre_rst", 2, 1, 1, 11'h321, 11'h123);
    #3;
    rst = 1'b1;
    #1;
    check_state("async_rst", 0, 1, 0, 11'h000, 11'h000);
    #1;
    rst = 1'b0;
    step();
    check_state("post_rst", 0, 1, 0, 11'h000, 11'h000);

    // Queue still works after reset.
    drive(0, 1, 11'h7AB, 11'h0CD, 0);
    step();
    drive(0, 0, '0, '0, 0);
    check_state("post_rst_push", 1, 1, 1, 11'h7AB, 11'h0CD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
